// File: rtl/rgb_mix_pkg.sv
// ---------------------------------------------------------------------------
// rgb_mix_pkg
// Shared types and helpers for the RGB mix controller.
//   duty_t       : 8-bit duty / colour channel value
//   rgb_t        : packed {red, green, blue} triple, red in the MSBs
//   ctrl_state_t : preset sequencer states (TRACK follows the encoders,
//                  HOLD sources targets from the saved preset)
//   gamma_map    : perceptual duty curve, (w*w + 255) >> 8
// Configuration macro: RGB_MIX_GAMMA_EN (consumed by rgb_mix_controller).
// ---------------------------------------------------------------------------
package rgb_mix_pkg;

  typedef logic [7:0] duty_t;

  typedef struct packed {
    duty_t red;
    duty_t green;
    duty_t blue;
  } rgb_t;

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } ctrl_state_t;

  // Squares the linear value and rounds up so that 255 maps back to 255
  // while 0 stays 0. The sum peaks at 65280, so 16 bits are enough.
  function automatic duty_t gamma_map(input duty_t w);
    logic [15:0] sq;
    sq = 16'(w) * 16'(w) + 16'd255;
    return sq[15:8];
  endfunction

endpackage

// File: rtl/rgb_channel_ramp.sv
// ---------------------------------------------------------------------------
// rgb_channel_ramp
// One colour channel's working value. In manual mode it copies the target
// every cycle; in fade mode it moves toward the target by at most STEP_SIZE
// on each prescaler tick, never overshooting and never wrapping.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   target     : value the channel is heading for
//   tick       : one-cycle fade step strobe
//   mode_fade  : 0 = manual (snap), 1 = rate-limited fade
//   working    : current linear working value
//   busy       : working differs from target (combinational)
// ---------------------------------------------------------------------------
module rgb_channel_ramp
  import rgb_mix_pkg::*;
#(
  parameter int STEP_SIZE = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  duty_t target,
  input  logic  tick,
  input  logic  mode_fade,
  output duty_t working,
  output logic  busy
);

  duty_t      working_reg;
  duty_t      working_next;
  logic [8:0] tgt9;
  logic [8:0] cur9;
  logic [8:0] diff9;
  logic [8:0] step9;
  logic [8:0] faded9;
  logic       going_up;

  // The step is clipped to the remaining distance, so the result always
  // lands between the current value and the target (0..255 inclusive).
  always_comb begin
    tgt9     = {1'b0, target};
    cur9     = {1'b0, working_reg};
    going_up = (tgt9 >= cur9);
    diff9    = going_up ? (tgt9 - cur9) : (cur9 - tgt9);
    step9    = (diff9 < 9'(STEP_SIZE)) ? diff9 : 9'(STEP_SIZE);
    faded9   = going_up ? (cur9 + step9) : (cur9 - step9);

    working_next = working_reg;
    if (!mode_fade) begin
      working_next = target;
    end else if (tick) begin
      working_next = 8'(faded9);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      working_reg <= '0;
    end else begin
      working_reg <= working_next;
    end
  end

  assign working = working_reg;
  assign busy    = (working_reg != target);

endmodule

// File: rtl/rgb_mix_controller.sv
// ---------------------------------------------------------------------------
// rgb_mix_controller
// Sequencer between the three encoder counts and the three PWM drivers.
// Runs a manual (direct) or fade (rate-limited) mode, keeps a one-slot
// colour preset with save/recall, and commits duties only on PWM period
// boundaries so no PWM period ever sees a mid-period duty change.
// Ports:
//   clk, rst                   : clock, asynchronous active-low reset
//   red_in/green_in/blue_in    : encoder counts
//   mode_fade                  : 0 = manual, 1 = fade
//   save, recall               : single-cycle preset strobes (save wins)
//   period_start               : PWM counter wrap strobe, commit point
//   red_duty/green_duty/blue_duty : committed duties to the PWM drivers
//   busy                       : some working value differs from its target
//   recall_active              : targets currently come from the preset
// Configuration macro: RGB_MIX_GAMMA_EN -- when defined the committed duty
// is gamma-shaped; fading and busy always use the linear working values.
// ---------------------------------------------------------------------------
module rgb_mix_controller
  import rgb_mix_pkg::*;
#(
  parameter int STEP_DIV  = 1024,
  parameter int STEP_SIZE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  input  logic       mode_fade,
  input  logic       save,
  input  logic       recall,
  input  logic       period_start,
  output logic [7:0] red_duty,
  output logic [7:0] green_duty,
  output logic [7:0] blue_duty,
  output logic       busy,
  output logic       recall_active
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  // -------------------------------------------------------------------------
  // Fade prescaler: free-running 0..STEP_DIV-1, tick on the wrap cycle
  // -------------------------------------------------------------------------
  logic [PW-1:0] presc_reg;
  logic          tick;

  assign tick = (presc_reg == PW'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Preset sequencer FSM
  // -------------------------------------------------------------------------
  ctrl_state_t state_reg;
  ctrl_state_t state_next;
  rgb_t        enc;
  rgb_t        snap_reg;
  rgb_t        preset_reg;
  rgb_t        target;
  logic        snap_load;
  logic        recall_ok;

  assign enc       = {red_in, green_in, blue_in};
  assign recall_ok = recall && !save;   // save takes priority over recall

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= TRACK;
    end else begin
      state_reg <= state_next;
    end
  end

  // A recall (re)arms the snapshot; while holding, any encoder movement
  // relative to that snapshot hands control back to the encoders.
  always_comb begin
    state_next = state_reg;
    snap_load  = 1'b0;
    case (state_reg)
      TRACK: begin
        if (recall_ok) begin
          state_next = HOLD;
          snap_load  = 1'b1;
        end
      end
      HOLD: begin
        if (recall_ok) begin
          snap_load = 1'b1;
        end else if (enc != snap_reg) begin
          state_next = TRACK;
        end
      end
      default: state_next = TRACK;
    endcase
  end

  always_comb begin
    target        = (state_reg == HOLD) ? preset_reg : enc;
    recall_active = (state_reg == HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_reg   <= '0;
      preset_reg <= '0;
    end else begin
      if (snap_load) begin
        snap_reg <= enc;
      end
      if (save) begin
        preset_reg <= enc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel ramps and period-aligned commit
  // -------------------------------------------------------------------------
  duty_t      target_ch  [3];
  duty_t      working_ch [3];
  duty_t      commit_ch  [3];
  duty_t      duty_reg   [3];
  logic [2:0] ch_busy;
  logic       busy_reg;

  assign target_ch[0] = target.red;
  assign target_ch[1] = target.green;
  assign target_ch[2] = target.blue;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      rgb_channel_ramp #(
        .STEP_SIZE (STEP_SIZE)
      ) u_ramp (
        .clk       (clk),
        .rst       (rst),
        .target    (target_ch[gi]),
        .tick      (tick),
        .mode_fade (mode_fade),
        .working   (working_ch[gi]),
        .busy      (ch_busy[gi])
      );

`ifdef RGB_MIX_GAMMA_EN
      assign commit_ch[gi] = gamma_map(working_ch[gi]);
`else
      assign commit_ch[gi] = working_ch[gi];
`endif

      // Commit samples the working value present before this edge, so a
      // coinciding fade tick only shows up at the next period.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          duty_reg[gi] <= '0;
        end else if (period_start) begin
          duty_reg[gi] <= commit_ch[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= |ch_busy;
    end
  end

  assign red_duty   = duty_reg[0];
  assign green_duty = duty_reg[1];
  assign blue_duty  = duty_reg[2];
  assign busy       = busy_reg;

endmodule

// File: tb/tb_rgb_mix_controller.sv
// ---------------------------------------------------------------------------
// tb_rgb_mix_controller
// Directed bench for rgb_mix_controller (STEP_DIV=4, STEP_SIZE=4). Expected
// duties are queued when a period_start is driven and compared after the
// commit edge; level outputs are checked directly at chosen points.
// ---------------------------------------------------------------------------
module tb_rgb_mix_controller;

  logic       clk;
  logic       rst;
  logic [7:0] red_in;
  logic [7:0] green_in;
  logic [7:0] blue_in;
  logic       mode_fade;
  logic       save;
  logic       recall;
  logic       period_start;
  logic [7:0] red_duty;
  logic [7:0] green_duty;
  logic [7:0] blue_duty;
  logic       busy;
  logic       recall_active;

  int          total;
  int          bad;
  int          edges;
  logic [23:0] exp_q[$];

  rgb_mix_controller #(
    .STEP_DIV  (4),
    .STEP_SIZE (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .red_in        (red_in),
    .green_in      (green_in),
    .blue_in       (blue_in),
    .mode_fade     (mode_fade),
    .save          (save),
    .recall        (recall),
    .period_start  (period_start),
    .red_duty      (red_duty),
    .green_duty    (green_duty),
    .blue_duty     (blue_duty),
    .busy          (busy),
    .recall_active (recall_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the DUT prescaler value equals edges % 4.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  function automatic logic [7:0] shape(input logic [7:0] w);
`ifdef RGB_MIX_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(w) * 16'(w) + 16'd255;
    return sq[15:8];
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    red_in   = r;
    green_in = g;
    blue_in  = b;
  endtask

  // One clock; clears strobes and scores a commit if one was driven.
  task automatic cycle();
    logic [23:0] e;
    logic        was_commit;
    was_commit = period_start;
    @(posedge clk);
    #1;
    save         = 1'b0;
    recall       = 1'b0;
    period_start = 1'b0;
    if (was_commit) begin
      e = exp_q.pop_front();
      $display("commit t=%0t duty=%0d,%0d,%0d expected=%0d,%0d,%0d busy=%0d recall_active=%0d",
               $time, red_duty, green_duty, blue_duty, e[23:16], e[15:8], e[7:0],
               busy, recall_active);
      check("red_duty",   red_duty,   e[23:16]);
      check("green_duty", green_duty, e[15:8]);
      check("blue_duty",  blue_duty,  e[7:0]);
    end
  endtask

  task automatic commit(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    period_start = 1'b1;
    exp_q.push_back({shape(r), shape(g), shape(b)});
    cycle();
  endtask

  task automatic align();
    while (edges % 4 != 0) cycle();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b0;
    mode_fade    = 1'b0;
    save         = 1'b0;
    recall       = 1'b0;
    period_start = 1'b0;
    set_in(8'd0, 8'd0, 8'd0);

    // Reset state
    #12;
    check("rst_red",    red_duty,   8'd0);
    check("rst_green",  green_duty, 8'd0);
    check("rst_blue",   blue_duty,  8'd0);
    check("rst_busy",   8'(busy),   8'd0);
    check("rst_recall", 8'(recall_active), 8'd0);
    rst = 1'b1;

    // Manual mode: duties wait for the period boundary
    set_in(8'd200, 8'd100, 8'd50);
    cycle();
    check("man_hold_red",  red_duty,   8'd0);
    check("man_hold_blue", blue_duty,  8'd0);
    check("man_busy_1",    8'(busy),   8'd1);
    repeat (254) cycle();
    check("man_pre_green", green_duty, 8'd0);
    commit(8'd200, 8'd100, 8'd50);
    check("man_busy_0", 8'(busy), 8'd0);

    // Fade up 0 -> 10 on red
    set_in(8'd0, 8'd0, 8'd0);
    cycle();
    cycle();
    align();
    mode_fade = 1'b1;
    set_in(8'd10, 8'd0, 8'd0);
    repeat (4) cycle();                 // tick: working 4
    check("fade_busy_a", 8'(busy), 8'd1);
    commit(8'd4, 8'd0, 8'd0);
    repeat (2) cycle();
    commit(8'd4, 8'd0, 8'd0);           // coincides with tick: pre-tick value
    commit(8'd8, 8'd0, 8'd0);
    repeat (3) cycle();                 // tick: working 10
    check("fade_busy_b", 8'(busy), 8'd1);
    commit(8'd10, 8'd0, 8'd0);
    check("fade_busy_done", 8'(busy), 8'd0);
    repeat (3) cycle();                 // tick with nothing left to move
    commit(8'd10, 8'd0, 8'd0);

    // Manual snap mid-fade, then fade down 3 -> 0 without underflow
    align();
    mode_fade = 1'b0;
    set_in(8'd3, 8'd0, 8'd0);
    cycle();
    mode_fade = 1'b1;
    set_in(8'd0, 8'd0, 8'd0);
    commit(8'd3, 8'd0, 8'd0);
    repeat (2) cycle();
    commit(8'd0, 8'd0, 8'd0);

    // Fade up 253 -> 255 without wrap
    align();
    mode_fade = 1'b0;
    set_in(8'd0, 8'd0, 8'd253);
    cycle();
    mode_fade = 1'b1;
    set_in(8'd0, 8'd0, 8'd255);
    repeat (3) cycle();
    commit(8'd0, 8'd0, 8'd255);
    check("clamp_busy", 8'(busy), 8'd0);

    // Save / recall / encoder override
    mode_fade = 1'b0;
    set_in(8'd10, 8'd20, 8'd30);
    save = 1'b1;
    cycle();
    set_in(8'd90, 8'd90, 8'd90);
    recall = 1'b1;
    cycle();
    check("recall_on", 8'(recall_active), 8'd1);
    cycle();
    commit(8'd10, 8'd20, 8'd30);
    green_in = 8'd91;
    cycle();
    check("recall_off", 8'(recall_active), 8'd0);
    cycle();
    commit(8'd90, 8'd91, 8'd90);

    // Save and recall together: save wins
    set_in(8'd5, 8'd6, 8'd7);
    save   = 1'b1;
    recall = 1'b1;
    cycle();
    check("both_recall", 8'(recall_active), 8'd0);
    set_in(8'd1, 8'd1, 8'd1);
    recall = 1'b1;
    cycle();
    check("both_recall2", 8'(recall_active), 8'd1);
    cycle();
    commit(8'd5, 8'd6, 8'd7);
    set_in(8'd2, 8'd2, 8'd2);
    cycle();
    check("both_exit", 8'(recall_active), 8'd0);

    // Reset mid-fade clears outputs without a clock edge
    set_in(8'd120, 8'd60, 8'd30);
    cycle();
    commit(8'd120, 8'd60, 8'd30);
    mode_fade = 1'b1;
    set_in(8'd250, 8'd250, 8'd250);
    repeat (2) cycle();
    check("pre_rst_busy", 8'(busy), 8'd1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_red",   red_duty,   8'd0);
    check("arst_green", green_duty, 8'd0);
    check("arst_blue",  blue_duty,  8'd0);
    check("arst_busy",  8'(busy),   8'd0);
    #10;
    rst = 1'b1;
    cycle();
    check("post_rst_red", red_duty, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_mix_controller.md
Name: rgb_mix_controller

Overview:
Sequencer between the three rotary-encoder counts and the three PWM drivers of the RGB mixer. It runs either a direct manual mode or a rate-limited fade toward target colours. It provides a one-slot colour preset (save/recall). Duty updates to the PWM drivers are committed only at PWM period boundaries, so each PWM period is glitch-free.

Parameters:
STEP_DIV, 1024, clk cycles per fade tick (>=1)
STEP_SIZE, 4, duty LSBs moved per fade tick per channel (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
red_in  in  8  red encoder count
green_in  in  8  green encoder count
blue_in  in  8  blue encoder count
mode_fade  in  1  level; 0 = manual, 1 = fade
save  in  1  single-cycle pulse, already synchronised
recall  in  1  single-cycle pulse, already synchronised
period_start  in  1  single-cycle pulse at PWM counter wrap
red_duty  out  8  committed duty to red PWM driver
green_duty  out  8  committed duty to green PWM driver
blue_duty  out  8  committed duty to blue PWM driver
busy  out  1  any working value differs from its target
recall_active  out  1  targets are sourced from the preset

Behaviour:
- Reset (rst=0, async): all duties 0, working values 0, preset 0, state TRACK, recall_active 0, busy 0, prescaler 0.
- Target source per state:
  - TRACK: target = {red_in, green_in, blue_in}.
  - HOLD: target = preset.
- FSM transitions:
  - TRACK -> HOLD on recall. Capture a snapshot of the encoder inputs that cycle.
  - HOLD -> TRACK in the first cycle any encoder input differs from the snapshot.
  - HOLD + recall: stay in HOLD, re-snapshot.
  - recall_active = (state == HOLD), registered.
- save: preset <= current encoder inputs on the next edge; state unchanged.
  - save and recall in the same cycle: save wins, recall ignored.
- Prescaler: counts 0..STEP_DIV-1 and issues a one-cycle tick at wrap. Free-running in both modes.
- Working value update:
  - mode_fade=0: working <= target every cycle.
  - mode_fade=1: on each tick, each channel moves toward its target by min(STEP_SIZE, |target-working|). Never overshoots. Arithmetic is 9-bit internally, with no wrap below 0 or above 255.
  - Target change mid-fade: the fade continues from the current working value toward the new target.
- Commit: on period_start, duty outputs <= working values (registered, all three simultaneously).
  - Latency from target change in manual mode: 1 cycle into working, then the next period_start.
  - If period_start and a tick coincide, the commit uses the pre-tick working value.
- busy: combinational OR over channels of (working != target), registered.
- Mode switch 1->0 mid-fade: working snaps to target on the next edge.
- Reset mid-fade: everything returns to reset values immediately.

Optional Feature:
RGB_MIX_GAMMA_EN
- Defined: committed duty = (w*w + 255) >> 8 per channel, computed at commit time (0->0, 255->255, 128->64).
- Undefined: committed duty = working value unchanged.
- busy and fade arithmetic always operate on linear working values.

Decomposition:
- Package rgb_mix_pkg: typedef duty_t (logic [7:0]); packed struct rgb_t {red, green, blue}; enum ctrl_state_t {TRACK, HOLD}; gamma function.
- Sub-module rgb_channel_ramp, instantiated x3. Inputs: target, tick, mode_fade. Outputs: working value and per-channel busy.
- The FSM, prescaler and commit register stay in the top.

Test Plan:
- Manual mode, inputs {200,100,50}, period_start every 256 cycles -> duties {0,0,0} until the first period_start after the change, then {200,100,50}; busy=0.
- Fade mode, STEP_DIV=4, STEP_SIZE=4, red target 10 from 0 -> red working 4, 8, 10 on successive ticks with no overshoot; busy deasserts the cycle after working reaches 10.
- Fade down, working 3, target 0, STEP_SIZE=4 -> working 0 in one tick, no underflow to 255.
- Inputs {10,20,30} + save, then inputs {90,90,90} + recall -> recall_active=1 and targets {10,20,30}. Change green_in to 91 -> recall_active=0 and targets follow the encoders.
- save and recall in the same cycle -> preset updated, recall_active stays 0.
- Reset asserted mid-fade with duties {120,60,30} -> all outputs 0 immediately, without waiting for a clk edge.
